// File: rtl/fifo_rr_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port between n_req requesters.
// Grants lock for bursts of up to max_burst beats; pushed words carry the winner id.
module fifo_rr_push_arbiter #(
  parameter int unsigned n_req     = 4,
  parameter int unsigned width     = 8,
  parameter int unsigned max_burst = 4,
  localparam int unsigned id_width = $clog2(n_req)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [n_req-1:0]          i_req_valid,
  input  logic [n_req*width-1:0]    i_req_data,
  input  logic [n_req-1:0]          i_req_last,
  output logic [n_req-1:0]          o_req_ready,
  output logic                      o_fifo_push,
  output logic [id_width+width-1:0] o_fifo_write_data,
  input  logic                      i_fifo_full,
  output logic [id_width-1:0]       o_grant_id,
  output logic                      o_busy
);

  localparam int unsigned CntW = (max_burst > 1) ? $clog2(max_burst) : 1;

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e              r_state;
  logic [id_width-1:0] r_rr_ptr;
  logic [id_width-1:0] r_owner;
  logic [id_width-1:0] r_last_winner;
  logic [CntW-1:0]     r_beat_cnt;

  logic                w_win_found;
  logic [id_width-1:0] w_winner;
  logic [id_width-1:0] w_gnt_idx;
  logic                w_gnt_valid;
  logic                w_gnt_last;
  logic                w_xfer;
  logic [width-1:0]    w_gnt_data;

  function automatic logic [id_width-1:0] wrap_inc(input logic [id_width-1:0] v);
    return (32'(v) == n_req - 1) ? '0 : v + 1'b1;
  endfunction

  // Priority scan starting at r_rr_ptr, wrapping modulo n_req.
  always_comb begin
    w_win_found = 1'b0;
    w_winner    = '0;
    for (int unsigned k = 0; k < n_req; k++) begin
      logic [id_width-1:0] cand;
      cand = id_width'((32'(r_rr_ptr) + k) % n_req);
      if (!w_win_found && i_req_valid[cand]) begin
        w_win_found = 1'b1;
        w_winner    = cand;
      end
    end
  end

  always_comb begin
    w_gnt_idx   = (r_state == StBurst) ? r_owner : w_winner;
    w_gnt_valid = (r_state == StBurst) ? i_req_valid[r_owner] : w_win_found;
    w_gnt_last  = i_req_last[w_gnt_idx];
    w_gnt_data  = i_req_data[w_gnt_idx*width +: width];
    w_xfer      = w_gnt_valid & ~i_fifo_full;
  end

  always_comb begin
    o_req_ready = '0;
    if (r_state == StBurst || w_win_found) begin
      o_req_ready[w_gnt_idx] = ~i_fifo_full;
    end
    o_fifo_push       = w_xfer;
    o_fifo_write_data = {w_gnt_idx, w_gnt_data};
    if (r_state == StBurst) begin
      o_grant_id = r_owner;
    end else if (w_win_found) begin
      o_grant_id = w_winner;
    end else begin
      o_grant_id = r_last_winner;
    end
    o_busy = (r_state == StBurst);
  end

  // Registers only move on an accepted beat, so a full FIFO freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= StIdle;
      r_rr_ptr      <= '0;
      r_owner       <= '0;
      r_last_winner <= '0;
      r_beat_cnt    <= '0;
    end else if (w_xfer) begin
      r_last_winner <= w_gnt_idx;
      unique case (r_state)
        StIdle: begin
          if (w_gnt_last || max_burst == 1) begin
            r_rr_ptr <= wrap_inc(w_winner);
          end else begin
            r_state    <= StBurst;
            r_owner    <= w_winner;
            r_beat_cnt <= CntW'(1);
          end
        end
        StBurst: begin
          if (w_gnt_last || r_beat_cnt == CntW'(max_burst - 1)) begin
            r_state    <= StIdle;
            r_rr_ptr   <= wrap_inc(r_owner);
            r_beat_cnt <= '0;
          end else begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_rr_push_arbiter.md
# fifo_rr_push_arbiter

Round-robin write arbiter that shares one flip-flop FIFO push port between `n_req` requesters. Each requester presents data with a valid/ready handshake and an optional burst-end marker. The arbiter locks the grant for bursts of up to `max_burst` beats and tags every pushed word with the winner's index. It sits directly in front of the FIFO: it drives the FIFO's `push` and `write_data` and observes its `full`.

## Interface
- `n_req`, default 4: number of requesters, at least 2.
- `width`, default 8: payload width per requester.
- `max_burst`, default 4: maximum beats per grant, at least 1.
- `id_width`, derived as `$clog2(n_req)`, not overridable.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  n_req  bit i: requester i has a beat.
- `req_data`  in  n_req*width  requester i payload in bits [i*width +: width].
- `req_last`  in  n_req  bit i: current beat ends requester i's burst.
- `req_ready`  out  n_req  bit i: beat of requester i accepted this cycle when valid.
- `fifo_push`  out  1  push strobe to the FIFO.
- `fifo_write_data`  out  id_width+width  {winner id, payload}.
- `fifo_full`  in  1  FIFO full flag.
- `grant_id`  out  id_width  current or most recent winner.
- `busy`  out  1  high while in BURST.

## Operation
- State registers:
  - `state`: IDLE or BURST.
  - `rr_ptr` (id_width): highest-priority requester.
  - `owner` (id_width): locked requester.
  - `beat_cnt`: counts 0..max_burst-1.
- IDLE:
  - Winner = first i with `req_valid[i]`=1, scanning `rr_ptr`, `rr_ptr`+1, …, wrapping modulo `n_req`.
  - `req_ready[winner]` = ~`fifo_full`; every other ready bit is 0.
  - A transfer happens when the winner is valid and ~`fifo_full`.
  - On a transfer with `req_last`=1, or with `max_burst`=1: stay in IDLE and set `rr_ptr` = winner+1 (mod `n_req`).
  - On a transfer with `req_last`=0 and `max_burst`>1: go to BURST, set `owner` = winner and `beat_cnt` = 1.
- BURST:
  - Only `req_ready[owner]` may assert, equal to ~`fifo_full`.
  - Other requesters are ignored even if valid.
  - On a transfer: increment `beat_cnt`.
  - The burst ends on a transfer with `req_last`=1, or when `beat_cnt` = max_burst-1 (the beat making max_burst).
  - On burst end: go to IDLE, set `rr_ptr` = owner+1 (mod `n_req`), clear `beat_cnt`.
  - If the owner drops valid, stay in BURST and wait. There is no timeout.
- `fifo_push` = (granted `req_valid`) & ~`fifo_full`. The arbiter never pushes into a full FIFO.
- `fifo_write_data` = {granted index, granted payload}. It is don't-care when `fifo_push`=0.
- `grant_id`:
  - In IDLE with a valid requester: the combinational winner.
  - In BURST: `owner`.
  - Otherwise: holds the registered last winner.
- `busy` = (state == BURST).
- Index arithmetic wraps modulo `n_req`; `n_req` need not be a power of two.

## Timing
- Reset values:
  - Registers: state IDLE, `rr_ptr`=0, `owner`=0, `beat_cnt`=0, last winner=0.
  - Outputs with no valid input: `req_ready`=0, `fifo_push`=0, `grant_id`=0, `busy`=0.
- Zero-cycle combinational path from `req_valid`/`fifo_full` to `req_ready`/`fifo_push`. The FIFO captures data on the same edge that completes the handshake.
- State, pointer and counter update on the rising `clk` edge after a transfer. The next beat or winner is visible in the following cycle.
- `fifo_full` high: no ready, no push, and no register changes, in either state.
- `fifo_full` deasserting mid-burst resumes the same owner with no re-arbitration.
- Simultaneous valids in IDLE: exactly one winner per cycle; no requester waits more than `n_req`-1 grants.
- `req_last`=1 on the first beat: single-beat grant, no BURST entry.
- `rst` asserted mid-burst: immediate return to IDLE with `rr_ptr`=0. An unaccepted beat is not pushed, and the FIFO is reset by the same `rst`.

## Test plan
- Reset, then requesters 0 and 2 both valid with `req_last`=1 and FIFO not full:
  - Cycle 1 pushes id 0 and `rr_ptr` becomes 1.
  - Cycle 2 pushes id 2 and `rr_ptr` becomes 3.
- All 4 requesters valid continuously with `req_last`=1: pushed ids follow 0,1,2,3,0,1, one push per cycle.
- Requester 1 sends 6 beats with `req_last`=0 and `max_burst`=4:
  - 4 consecutive pushes tagged id 1, with `busy` high during beats 2–4.
  - Then IDLE, re-arbitration, and requester 3 is served next if valid.
- `fifo_full` held high for 3 cycles mid-burst of requester 2: `fifo_push`=0 and `req_ready`=0 for those cycles, `beat_cnt` is unchanged, and the burst resumes with id 2 afterwards.
- Owner 0 drops valid for 2 cycles mid-burst while requester 1 is valid:
  - No push and no grant to 1 during the gap.
  - Burst continues when 0 returns.
- `rst` pulsed while in BURST at `beat_cnt`=2:
  - Outputs return to reset values asynchronously.
  - Next arbitration starts from `rr_ptr`=0.
